// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with frame-synchronous shadow loading,
// leading-zero blanking and per-slot PWM dimming; anode/cathode are active-low and registered.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              anode,
    output logic [7:0]              cathode,
    output logic                    frame_done
);

    localparam int unsigned CW      = $clog2(TICK_DIV);
    localparam int unsigned PW      = BRIGHT_W + 32;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [2:0]    IDX_MAX = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic          live_q, live_d;
    logic          fd_q, fd_d;
    logic [31:0]   sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
    logic [7:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [7:0]    sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic [7:0]    anode_q, anode_d;
    logic [7:0]    cathode_q, cathode_d;

    logic [31:0]   in_dig;
    logic [7:0]    in_dp, in_en;
    logic          tick, wrap;
    logic [PW-1:0] on_val;
    logic          lit;
    logic [3:0]    nib;
    logic [7:0]    blank;
    logic          zeros_above;

    // Internal copies are padded to 8 digits so a 3-bit index never overruns a vector.
    assign in_dig = 32'(digits);
    assign in_dp  = 8'(dp_in);
    assign in_en  = 8'(digit_en);

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        wrap  = tick && (idx_q == IDX_MAX);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end

        sh_dig_d  = sh_dig_q;
        sh_dp_d   = sh_dp_q;
        sh_en_d   = sh_en_q;
        act_dig_d = act_dig_q;
        act_dp_d  = act_dp_q;
        act_en_d  = act_en_q;
        pend_d    = pend_q;

        if (load) begin
            sh_dig_d = in_dig;
            sh_dp_d  = in_dp;
            sh_en_d  = in_en;
        end

        // A load landing on the wrap tick bypasses the shadow and leaves nothing pending.
        if (wrap) begin
            pend_d = 1'b0;
            if (load) begin
                act_dig_d = in_dig;
                act_dp_d  = in_dp;
                act_en_d  = in_en;
            end else if (pend_q) begin
                act_dig_d = sh_dig_q;
                act_dp_d  = sh_dp_q;
                act_en_d  = sh_en_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end

        // frame_done stays quiet until some load has reached the active registers.
        live_d = live_q | (wrap & (load | pend_q));
        fd_d   = wrap & live_d;
    end

    always_comb begin
        on_val = ((PW'(brightness) + PW'(1)) * PW'(TICK_DIV)) >> BRIGHT_W;
        lit    = (PW'(cnt_q) < on_val);
        nib    = act_dig_q[{idx_q, 2'b00} +: 4];

        zeros_above = 1'b1;
        blank       = '0;
        for (int i = 7; i >= 0; i--) begin
            blank[i] = blank_lz && (i != 0) && (act_dig_q[i*4 +: 4] == 4'h0) && zeros_above;
            if (act_en_q[i] && (act_dig_q[i*4 +: 4] != 4'h0)) begin
                zeros_above = 1'b0;
            end
        end

        anode_d   = 8'hFF;
        cathode_d = 8'hFF;
        if (act_en_q[idx_q] && lit) begin
            anode_d[idx_q] = 1'b0;
            cathode_d      = {~act_dp_q[idx_q], blank[idx_q] ? 7'h7F : ~hex_seg(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            pend_q    <= 1'b0;
            live_q    <= 1'b0;
            fd_q      <= 1'b0;
            sh_dig_q  <= '0;
            sh_dp_q   <= '0;
            sh_en_q   <= '0;
            act_dig_q <= '0;
            act_dp_q  <= '0;
            act_en_q  <= '0;
            anode_q   <= 8'hFF;
            cathode_q <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            live_q    <= live_d;
            fd_q      <= fd_d;
            sh_dig_q  <= sh_dig_d;
            sh_dp_q   <= sh_dp_d;
            sh_en_q   <= sh_en_d;
            act_dig_q <= act_dig_d;
            act_dp_q  <= act_dp_d;
            act_en_q  <= act_en_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors through a scoreboard queue, plus hand sequences for
// shadow loading, reset and PWM duty (second instance with TICK_DIV = 16).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [7:0]  anode, cathode, anode2, cathode2;
    logic        frame_done, frame_done2;

    int n_chk = 0;
    int n_err = 0;

    seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4), .BRIGHT_W(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .anode      (anode),
        .cathode    (cathode),
        .frame_done (frame_done)
    );

    seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(16), .BRIGHT_W(4)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .anode      (anode2),
        .cathode    (cathode2),
        .frame_done (frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blz;
        logic [31:0] an;   // byte d = expected anode during digit d's slot
        logic [31:0] ca;   // byte d = expected cathode during digit d's slot
    } vec_t;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] ca;
    } exp_t;

    vec_t vecs [9];
    exp_t sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fd(input int which, input int limit);
        int n = 0;
        while (((which == 1) ? frame_done : frame_done2) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk((which == 1) ? "fd_seen" : "fd2_seen",
            32'((which == 1) ? frame_done : frame_done2), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   c1 [4];
        int   c2 [4];
        int   bvals [4] = '{7, 0, 3, 15};
        int   exp1  [4] = '{8, 0, 4, 16};
        int   exp2  [4] = '{8, 1, 4, 16};

        vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 32'hF7FBFDFE, 32'hF9A4B099};
        vecs[1] = '{16'h0050, 4'h0, 4'hF, 1'b1, 32'hF7FBFDFE, 32'hFFFF92C0};
        vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 32'hF7FBFDFE, 32'hFFFFFFC0};
        vecs[3] = '{16'hABCD, 4'h0, 4'hF, 1'b0, 32'hF7FBFDFE, 32'h8883C6A1};
        vecs[4] = '{16'h1234, 4'h1, 4'h5, 1'b0, 32'hFFFBFFFE, 32'hFFA4FF19};
        vecs[5] = '{16'hEF89, 4'h0, 4'hF, 1'b1, 32'hF7FBFDFE, 32'h868E8090};
        vecs[6] = '{16'h9007, 4'h0, 4'h7, 1'b1, 32'hFFFBFDFE, 32'hFFFFFFF8};
        vecs[7] = '{16'h0000, 4'h2, 4'hF, 1'b1, 32'hF7FBFDFE, 32'hFFFF7FC0};
        vecs[8] = '{16'h6666, 4'h8, 4'hF, 1'b1, 32'hF7FBFDFE, 32'h02828282};

        reset = 1'b1; load = 1'b0; digits = '0; dp_in = '0; digit_en = '0;
        blank_lz = 1'b0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({anode, cathode, frame_done}), 32'({8'hFF, 8'hFF, 1'b0}));
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_dark", 32'({anode, cathode, frame_done}), 32'({8'hFF, 8'hFF, 1'b0}));
        end

        for (int i = 0; i < 9; i++) begin
            digits = vecs[i].dig; dp_in = vecs[i].dp; digit_en = vecs[i].en;
            blank_lz = vecs[i].blz; load = 1'b1;
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    sb_q.push_back('{an: vecs[i].an[8*d +: 8], ca: vecs[i].ca[8*d +: 8]});
                end
            end
            @(negedge clk);
            load = 1'b0;
            wait_fd(1, 40);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                e = sb_q.pop_front();
                chk($sformatf("vec%0d_cyc%0d", i, k), 32'({anode, cathode}), 32'({e.an, e.ca}));
            end
        end

        // frame_done: one cycle wide, every 16 cycles
        wait_fd(1, 40);
        @(negedge clk);
        chk("fd_width", 32'(frame_done), 32'd0);
        n = 1;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_period", n, 16);

        // mid-frame load waits for the boundary
        digits = 16'h1234; dp_in = '0; digit_en = 4'hF; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd(1, 40);
        repeat (5) @(negedge clk);
        digits = 16'hABCD; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("midload_keep_d2", 32'({anode, cathode}), 32'h0000FBA4);
        repeat (4) @(negedge clk);
        chk("midload_keep_d3", 32'({anode, cathode}), 32'h0000F7F9);
        wait_fd(1, 20);
        @(negedge clk);
        chk("midload_new_d0", 32'({anode, cathode}), 32'h0000FEA1);
        repeat (4) @(negedge clk);
        chk("midload_new_d1", 32'({anode, cathode}), 32'h0000FDC6);

        // load on the wrap tick applies at that same boundary
        repeat (10) @(negedge clk);
        digits = 16'h5678; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("wrapload_fd", 32'(frame_done), 32'd1);
        @(negedge clk);
        chk("wrapload_new_d0", 32'({anode, cathode}), 32'h0000FE80);

        // reset mid-frame with a pending load and a coincident load
        repeat (3) @(negedge clk);
        digits = 16'hABCD; load = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid", 32'({anode, cathode, frame_done}), 32'({8'hFF, 8'hFF, 1'b0}));
        reset = 1'b0; load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("post_reset_dark", 32'({anode, cathode, frame_done}), 32'({8'hFF, 8'hFF, 1'b0}));
        end

        // index and prescaler restart from zero after reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; digits = 16'h1234; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("restart_frame", n, 15);

        // PWM duty over 64 cycles for both instances
        wait_fd(2, 100);
        for (int b = 0; b < 4; b++) begin
            brightness = 4'(bvals[b]);
            repeat (2) @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                c1[d] = 0;
                c2[d] = 0;
            end
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) begin
                    if (!anode[d])  c1[d]++;
                    if (!anode2[d]) c2[d]++;
                end
            end
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("pwm4_b%0d_d%0d", bvals[b], d), c1[d], exp1[b]);
                chk($sformatf("pwm16_b%0d_d%0d", bvals[b], d), c2[d], exp2[b]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of scanned digits, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per digit slot, legal range >= 2.
REQ-003 Parameter BRIGHT_W, default 4, width of the brightness control.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 load  input  1  strobe; captures digits, dp_in and digit_en into the shadow registers.
REQ-007 digits  input  4*NUM_DIGITS  hex nibbles; nibble i = digits[4i+3:4i]; digit 0 is least significant.
REQ-008 dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 digit_en  input  NUM_DIGITS  per-digit enable, 0 = digit dark.
REQ-010 blank_lz  input  1  1 = suppress leading zeros; sampled live, no shadowing.
REQ-011 brightness  input  BRIGHT_W  PWM duty code; sampled live.
REQ-012 anode  output  8  digit select, active-low; anode[i] drives digit i.
REQ-013 cathode  output  8  segments, active-low; cathode[6:0] = {g,f,e,d,c,b,a}, cathode[7] = dp.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 every cycle, wraps to 0; slot tick is asserted when count = TICK_DIV-1.
REQ-016 Digit index advances by 1 on each tick, wraps from NUM_DIGITS-1 to 0; NUM_DIGITS = 1 holds index at 0.
REQ-017 frame_done is asserted for exactly the one cycle after the tick on which index wraps NUM_DIGITS-1 -> 0.
REQ-018 load = 1 copies digits, dp_in, digit_en into shadow registers and sets a pending flag.
REQ-019 On the index wrap tick with pending = 1, active registers take the shadow values and pending clears; the display never changes mid-frame.
REQ-020 load coincident with the wrap tick: active registers take the current input values directly and pending stays 0.
REQ-021 Hex decode: standard 0-9, A, b, C, d, E, F glyphs for nibble values 0..15.
REQ-022 Leading-zero blank: with blank_lz = 1, digit i shows no segments a-g when its value is 0 and every enabled digit above i is 0 or blanked; digit 0 is never blanked; dp still follows active dp.
REQ-023 Disabled digit (active digit_en[i] = 0): anode[i] high for its entire slot.
REQ-024 anode bits NUM_DIGITS..7 are held high at all times.
REQ-025 PWM: anode[index] is asserted only while prescaler count < ON, ON = ((brightness+1) * TICK_DIV) >> BRIGHT_W, computed without overflow; maximum brightness gives ON = TICK_DIV (100 % duty).
REQ-026 ON = 0 (brightness too small for TICK_DIV) keeps the digit dark for the whole slot.
REQ-027 anode and cathode are registered; they reflect the prescaler/index state of the previous cycle (latency 1 clk).
REQ-028 When no anode is asserted, cathode = 8'hFF.

Reset
REQ-029 reset = 1 forces prescaler 0, index 0, pending 0, shadow and active registers all 0 (digit_en 0 = all dark) on the next edge.
REQ-030 Outputs during and after reset, until a load takes effect: anode = 8'hFF, cathode = 8'hFF, frame_done = 0.
REQ-031 reset mid-frame discards any pending load; reset dominates a simultaneous load.

Verification (NUM_DIGITS = 4, TICK_DIV = 4, BRIGHT_W = 4 unless stated)
REQ-032 Reset, load digits = 16'h1234, digit_en = 4'hF, brightness = 15 -> after the next frame boundary anode steps 8'hFE, FD, FB, F7 every 4 clk; cathode shows 4, 3, 2, 1 glyphs (4 = 8'h99 etc.); frame_done pulses once per 16 clk.
REQ-033 blank_lz = 1, digits = 16'h0050 -> digits 3, 2 show cathode 8'hFF while anodes 8'hF7/FB are asserted; digits 1, 0 show 5, 0; with digits = 16'h0000 only digit 0 shows 0.
REQ-034 Load 16'hABCD in mid-frame -> display keeps the old value until the wrap, then shows the new value starting from digit 0; load on the wrap tick -> new value applied at that same boundary.
REQ-035 TICK_DIV = 16, brightness = 7 -> ON = 8; each anode low for 8 of 16 cycles; brightness = 0 -> ON = 1, low 1 cycle per slot.
REQ-036 digit_en = 4'b0101, dp_in = 4'b0001 -> anodes 8'hFD, F7 never asserted; digit 0 cathode[7] = 0; assert reset mid-frame -> anode 8'hFF, cathode 8'hFF, index restarts at 0.
